// File: rtl/counter_checker.sv
// counter_checker: cycle-accurate scoreboard for the 4-bit mode counter.
// Define COUNTER_CHECKER_LOG_EN to print mismatches and per-reset summaries.
module counter_checker #(
    parameter int CNT_W       = 16,
    parameter int HALT_ON_ERR = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic [3:0]       D,
    input  logic [3:0]       dut_q,
    input  logic             dut_rco,
    input  logic             dut_load,
    output logic             err,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] chk_count,
    output logic             in_sync,
    output logic             failed,
    output logic [5:0]       first_exp,
    output logic [5:0]       first_got
);

    typedef enum logic [1:0] {
        S_VALID = 2'd0,
        S_LOST  = 2'd1,
        S_FAIL  = 2'd2
    } state_e;

    localparam logic [1:0]       M_ADD3  = 2'd0;
    localparam logic [1:0]       M_DEC   = 2'd1;
    localparam logic [1:0]       M_INC   = 2'd2;
    localparam logic [1:0]       M_LOAD  = 2'd3;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e           state_q, state_d;
    logic [3:0]       q_q, q_d;
    logic             rco_q, rco_d;
    logic             load_q, load_d;
    logic             cmp_pend_q, cmp_pend_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic [CNT_W-1:0] chk_count_q, chk_count_d;
    logic             in_sync_q, in_sync_d;
    logic             failed_q, failed_d;
    logic [5:0]       first_exp_q, first_exp_d;
    logic [5:0]       first_got_q, first_got_d;

    logic             cmp_act;
    logic             mism;
    logic [5:0]       cmp_exp;
    logic [5:0]       got_vec;

    assign got_vec = {dut_rco, dut_load, dut_q};

    // LOST has no trustworthy Q, so only rco/load are held against 0
    always_comb begin
        cmp_act = cmp_pend_q && (state_q != S_FAIL);
        cmp_exp = {rco_q, load_q, q_q};
        mism    = 1'b0;
        if (state_q == S_LOST) begin
            cmp_exp = {2'b00, q_q};
        end
        if (cmp_act) begin
            if (state_q == S_VALID) begin
                mism = (got_vec !== cmp_exp);
            end else begin
                mism = ({dut_rco, dut_load} !== 2'b00);
            end
        end
    end

    always_comb begin
        q_d        = q_q;
        rco_d      = 1'b0;
        load_d     = 1'b0;
        state_d    = state_q;
        cmp_pend_d = 1'b1;
        if (enable) begin
            case (mode)
                M_ADD3: begin
                    q_d   = q_q + 4'd3;
                    rco_d = (q_q >= 4'd13);
                end
                M_DEC: begin
                    q_d   = q_q - 4'd1;
                    rco_d = (q_q == 4'hF);
                end
                M_INC: begin
                    q_d   = q_q + 4'd1;
                    rco_d = (q_q == 4'hF);
                end
                default: begin
                    q_d    = D;
                    load_d = 1'b1;
                    rco_d  = (q_q == 4'hF);
                end
            endcase
            if ((mode == M_LOAD) && (state_q == S_LOST)) begin
                state_d = S_VALID;
            end
        end else if (state_q != S_FAIL) begin
            state_d = S_LOST;
        end
        if (mism && (HALT_ON_ERR != 0)) begin
            state_d = S_FAIL;
        end
    end

    always_comb begin
        err_d       = mism;
        err_count_d = err_count_q;
        chk_count_d = chk_count_q;
        failed_d    = failed_q | mism;
        first_exp_d = first_exp_q;
        first_got_d = first_got_q;
        in_sync_d   = (state_d == S_VALID);
        if (cmp_act && (chk_count_q != CNT_MAX)) begin
            chk_count_d = chk_count_q + 1'b1;
        end
        if (mism && (err_count_q != CNT_MAX)) begin
            err_count_d = err_count_q + 1'b1;
        end
        if (mism && !failed_q) begin
            first_exp_d = cmp_exp;
            first_got_d = got_vec;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_VALID;
            q_q         <= 4'd0;
            rco_q       <= 1'b0;
            load_q      <= 1'b0;
            cmp_pend_q  <= 1'b0;
            err_q       <= 1'b0;
            err_count_q <= '0;
            chk_count_q <= '0;
            in_sync_q   <= 1'b0;
            failed_q    <= 1'b0;
            first_exp_q <= 6'd0;
            first_got_q <= 6'd0;
        end else begin
            state_q     <= state_d;
            q_q         <= q_d;
            rco_q       <= rco_d;
            load_q      <= load_d;
            cmp_pend_q  <= cmp_pend_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
            chk_count_q <= chk_count_d;
            in_sync_q   <= in_sync_d;
            failed_q    <= failed_d;
            first_exp_q <= first_exp_d;
            first_got_q <= first_got_d;
        end
    end

    assign err       = err_q;
    assign err_count = err_count_q;
    assign chk_count = chk_count_q;
    assign in_sync   = in_sync_q;
    assign failed    = failed_q;
    assign first_exp = first_exp_q;
    assign first_got = first_got_q;

`ifdef COUNTER_CHECKER_LOG_EN
    logic             log_rst_q;
    logic [1:0]       log_mode_q;
    logic [CNT_W-1:0] log_chk_q;
    logic [CNT_W-1:0] log_err_q;

    // mode is delayed so the log names the edge whose result was compared
    always_ff @(posedge clk) begin
        log_rst_q  <= reset;
        log_mode_q <= mode;
        if (reset && !log_rst_q) begin
            log_chk_q <= chk_count_q;
            log_err_q <= err_count_q;
        end
        if (!reset && log_rst_q) begin
            $display("%0t counter_checker reset released: chk_count=%0d err_count=%0d",
                     $time, log_chk_q, log_err_q);
        end
        if (!reset && mism) begin
            $display("%0t counter_checker mismatch: state=%s mode=%0d exp=%b got=%b",
                     $time, state_q.name(), log_mode_q, cmp_exp, got_vec);
        end
    end
`endif

endmodule

// File: tb/tb_counter_checker.sv
// tb_counter_checker: randomized scoreboard bench for counter_checker.
// Three instances share stimulus: default, halt-on-error and 2-bit counters.
module tb_counter_checker;

    localparam int NI = 3;

    typedef struct {
        int         edge_n;
        bit         rst;
        bit         cmp;
        bit         mism;
        bit         valid_after;
        logic [5:0] exp;
        logic [5:0] got;
    } item_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [3:0] D = 4'd0;
    logic [3:0] dut_q = 4'd0;
    logic       dut_rco = 1'b0;
    logic       dut_load = 1'b0;

    logic        err0, err1, err2;
    logic [15:0] errc0, errc1, chkc0, chkc1;
    logic [1:0]  errc2, chkc2;
    logic        sync0, sync1, sync2;
    logic        fail0, fail1, fail2;
    logic [5:0]  fexp0, fexp1, fexp2;
    logic [5:0]  fgot0, fgot1, fgot2;

    always #5 clk = ~clk;

    counter_checker #(.CNT_W(16), .HALT_ON_ERR(0)) u_dut (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode), .D(D),
        .dut_q(dut_q), .dut_rco(dut_rco), .dut_load(dut_load),
        .err(err0), .err_count(errc0), .chk_count(chkc0), .in_sync(sync0),
        .failed(fail0), .first_exp(fexp0), .first_got(fgot0)
    );

    counter_checker #(.CNT_W(16), .HALT_ON_ERR(1)) u_halt (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode), .D(D),
        .dut_q(dut_q), .dut_rco(dut_rco), .dut_load(dut_load),
        .err(err1), .err_count(errc1), .chk_count(chkc1), .in_sync(sync1),
        .failed(fail1), .first_exp(fexp1), .first_got(fgot1)
    );

    counter_checker #(.CNT_W(2), .HALT_ON_ERR(0)) u_sat (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode), .D(D),
        .dut_q(dut_q), .dut_rco(dut_rco), .dut_load(dut_load),
        .err(err2), .err_count(errc2), .chk_count(chkc2), .in_sync(sync2),
        .failed(fail2), .first_exp(fexp2), .first_got(fgot2)
    );

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    bit    started = 1'b0;
    item_t sb_q[$];

    // reference counter as seen by the checker
    int mq = 0;
    bit mrco = 1'b0;
    bit mload = 1'b0;
    bit mvalid = 1'b1;
    bit pend = 1'b0;

    // per-instance expected outputs
    int         cmax[NI] = '{65535, 65535, 3};
    bit         halt_en[NI] = '{1'b0, 1'b1, 1'b0};
    int         m_errc[NI];
    int         m_chkc[NI];
    bit         m_err[NI];
    bit         m_failed[NI];
    bit         m_halted[NI];
    bit         m_insync[NI];
    logic [5:0] m_fexp[NI];
    logic [5:0] m_fgot[NI];

    task automatic check(input string name, input int inst, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s[%0d] edge=%0d got=%0h required=%0h", name, inst, cyc, got, exp);
        end
    endtask

    task automatic step(input bit rst, input bit en, input logic [1:0] md,
                        input logic [3:0] d, input bit inj_q, input bit inj_ctl);
        item_t      it;
        logic [3:0] gq;
        logic [1:0] gc;
        logic [5:0] ex;
        @(negedge clk);
        it.edge_n = cyc + 1;
        it.rst    = rst;
        it.cmp    = pend && !rst;
        if (pend) begin
            ex = mvalid ? {mrco, mload, 4'(mq)} : {2'b00, 4'(mq)};
            gq = mvalid ? 4'(mq) : 4'($urandom);
            gc = mvalid ? {mrco, mload} : 2'b00;
            if (inj_q) gq = gq ^ (4'd1 << $urandom_range(3, 0));
            if (inj_ctl) gc = gc ^ 2'($urandom_range(3, 1));
        end else begin
            ex = 6'd0;
            gq = 4'($urandom);
            gc = 2'($urandom);
        end
        it.exp  = ex;
        it.got  = {gc, gq};
        it.mism = mvalid ? ({gc, gq} != ex) : (gc != 2'b00);
        dut_q    = gq;
        dut_rco  = gc[1];
        dut_load = gc[0];
        reset    = rst;
        enable   = en;
        mode     = md;
        D        = d;
        if (rst) begin
            mq = 0; mrco = 1'b0; mload = 1'b0; mvalid = 1'b1; pend = 1'b0;
        end else begin
            pend = 1'b1;
            if (!en) begin
                mrco = 1'b0; mload = 1'b0; mvalid = 1'b0;
            end else begin
                mload = (md == 2'd3);
                mrco  = (md == 2'd0) ? (mq >= 13) : (mq == 15);
                case (md)
                    2'd0:    mq = (mq + 3) % 16;
                    2'd1:    mq = (mq + 15) % 16;
                    2'd2:    mq = (mq + 1) % 16;
                    default: mq = int'(d);
                endcase
                if (md == 2'd3) mvalid = 1'b1;
            end
        end
        it.valid_after = mvalid;
        sb_q.push_back(it);
        started = 1'b1;
    endtask

    item_t mon_it;
    int a_err[NI], a_errc[NI], a_chkc[NI], a_sync[NI], a_fail[NI], a_fexp[NI], a_fgot[NI];

    always @(posedge clk) begin
        cyc++;
        #1;
        if (started) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_empty edge=%0d got=0 items required=1", cyc);
            end else begin
                mon_it = sb_q.pop_front();
                check("sb_align", 0, mon_it.edge_n, cyc);
                for (int i = 0; i < NI; i++) begin
                    m_err[i] = 1'b0;
                    if (mon_it.rst) begin
                        m_errc[i] = 0; m_chkc[i] = 0; m_failed[i] = 1'b0;
                        m_halted[i] = 1'b0; m_insync[i] = 1'b0;
                        m_fexp[i] = 6'd0; m_fgot[i] = 6'd0;
                    end else begin
                        if (mon_it.cmp && !m_halted[i]) begin
                            if (m_chkc[i] < cmax[i]) m_chkc[i]++;
                            if (mon_it.mism) begin
                                m_err[i] = 1'b1;
                                if (m_errc[i] < cmax[i]) m_errc[i]++;
                                if (!m_failed[i]) begin
                                    m_fexp[i] = mon_it.exp;
                                    m_fgot[i] = mon_it.got;
                                end
                                m_failed[i] = 1'b1;
                                if (halt_en[i]) m_halted[i] = 1'b1;
                            end
                        end
                        m_insync[i] = mon_it.valid_after && !m_halted[i];
                    end
                end
                a_err  = '{int'(err0), int'(err1), int'(err2)};
                a_errc = '{int'(errc0), int'(errc1), int'(errc2)};
                a_chkc = '{int'(chkc0), int'(chkc1), int'(chkc2)};
                a_sync = '{int'(sync0), int'(sync1), int'(sync2)};
                a_fail = '{int'(fail0), int'(fail1), int'(fail2)};
                a_fexp = '{int'(fexp0), int'(fexp1), int'(fexp2)};
                a_fgot = '{int'(fgot0), int'(fgot1), int'(fgot2)};
                for (int i = 0; i < NI; i++) begin
                    check("err", i, a_err[i], int'(m_err[i]));
                    check("err_count", i, a_errc[i], m_errc[i]);
                    check("chk_count", i, a_chkc[i], m_chkc[i]);
                    check("in_sync", i, a_sync[i], int'(m_insync[i]));
                    check("failed", i, a_fail[i], int'(m_failed[i]));
                    check("first_exp", i, a_fexp[i], int'(m_fexp[i]));
                    check("first_got", i, a_fgot[i], int'(m_fgot[i]));
                end
            end
        end
    end

    initial begin
        repeat (2) step(1'b1, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0);
        // count up through wrap
        repeat (21) step(1'b0, 1'b1, 2'd2, 4'($urandom), 1'b0, 1'b0);
        // load 13 then +3 steps
        step(1'b0, 1'b1, 2'd3, 4'd13, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b1, 2'd0, 4'd0, 1'b0, 1'b0);
        // single Q corruption in down-count, then a second one later
        step(1'b0, 1'b1, 2'd1, 4'd0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 2'd1, 4'd0, 1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b1, 2'd1, 4'd0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 2'd1, 4'd0, 1'b1, 1'b0);
        // lose sync, count blind, resync on load 7
        repeat (3) step(1'b0, 1'b0, 2'd2, 4'd0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 2'd2, 4'd0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 2'd3, 4'd7, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b1, 2'd2, 4'd0, 1'b0, 1'b0);
        // burst of mismatches past the 2-bit limit, then reset mid-sequence
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 2'(i % 3), 4'd0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 2'd2, 4'd0, 1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b1, 2'd2, 4'd0, 1'b0, 1'b0);
        // randomized traffic with occasional resets and faults
        for (int i = 0; i < 400; i++) begin
            bit r_rst, r_en, r_iq, r_ic;
            r_rst = ($urandom_range(99, 0) < 2);
            r_en  = ($urandom_range(9, 0) != 0);
            r_iq  = ($urandom_range(99, 0) < 6);
            r_ic  = ($urandom_range(99, 0) < 4);
            step(r_rst, r_en, 2'($urandom), 4'($urandom), r_iq, r_ic);
        end
        step(1'b0, 1'b1, 2'd2, 4'd0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        check("sb_drained", 0, sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
